// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-side arbiter.
package fifo_arb_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_MAX_PKT = 16;
    localparam int DEF_TMO     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Round-robin pointer advance: the index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted req at or above rr_ptr, wrapping.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            valid,
    output logic [IW-1:0]   index
);

    int cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!valid && req[IW'(cand)]) begin
                valid = 1'b1;
                index = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter feeding one FIFO write port from NREQ sources,
// with forced release on oversize packets and on an owner that stops sending.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int DW      = DEF_DW,
    parameter int MAX_PKT = DEF_MAX_PKT,
    parameter int TMO     = DEF_TMO
) (
    input  logic                     clk,
    input  logic                     wreset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          last,
    input  logic [NREQ*DW-1:0]       din,
    output logic [NREQ-1:0]          ack,
    input  logic                     full,
    output logic                     winc,
    output logic [DW-1:0]            wdata,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic                     err
);

    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_PKT + 1);
    localparam int SW = $clog2(TMO + 1);

    arb_state_e    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          err_q, err_d;
    logic          pick_valid;
    logic [OW-1:0] pick_index;
    logic          owner_req;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (OW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .index  (pick_index)
    );

    // Write path is purely combinational; reset also blocks writes in its own cycle.
    assign owner_req = req[owner_q];
    assign winc      = (state_q == XFER) && owner_req && !full && !wreset;
    assign ack       = winc ? (NREQ'(1) << owner_q) : '0;
    assign wdata     = din[owner_q*DW +: DW];
    assign owner     = owner_q;
    assign busy      = (state_q == XFER);
    assign err       = err_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        stall_d  = stall_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d  = pick_index;
                    rr_ptr_d = OW'(wrap_inc(int'(pick_index), NREQ));
                    beat_d   = '0;
                    stall_d  = '0;
                    state_d  = XFER;
                end
            end
            XFER: begin
                if (winc) begin
                    stall_d = '0;
                    beat_d  = beat_q + 1'b1;
                    if (last[owner_q]) begin
                        state_d = IDLE;
                    end else if (beat_q == BW'(MAX_PKT - 1)) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else if (!owner_req) begin
                    // Only an absent owner counts toward the timeout; full back-pressure does not.
                    if (stall_q == SW'(TMO - 1)) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wreset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            stall_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester beat queues feed the DUT and
// are popped by an independent monitor that checks every write and every grant.
module tb_fifo_wr_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int MAX_PKT = 16;
    localparam int TMO     = 32;
    localparam int OW      = 2;

    logic                 clk = 1'b0;
    logic                 wreset = 1'b1;
    logic                 full = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      last = '0;
    logic [NREQ*DW-1:0]   din = '0;
    logic [NREQ-1:0]      ack;
    logic                 winc;
    logic [DW-1:0]        wdata;
    logic [OW-1:0]        owner;
    logic                 busy;
    logic                 err;

    logic [DW:0]          beatQ [NREQ][$];
    int                   grantQ[$];
    logic [NREQ-1:0]      gate = '1;
    bit                   checkGrants = 1'b1;
    int                   checks = 0;
    int                   errors = 0;
    int                   writeCnt = 0;
    int                   errPulses = 0;
    int                   errWriteMark = 0;
    logic [DW-1:0]        dataCtr = '0;

    fifo_wr_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .MAX_PKT (MAX_PKT),
        .TMO     (TMO)
    ) dut (
        .clk    (clk),
        .wreset (wreset),
        .req    (req),
        .last   (last),
        .din    (din),
        .ack    (ack),
        .full   (full),
        .winc   (winc),
        .wdata  (wdata),
        .owner  (owner),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pushPacket(input int i, input int n, input bit withLast);
        for (int k = 0; k < n; k++) begin
            beatQ[i].push_back({withLast && (k == n - 1), dataCtr});
            dataCtr++;
        end
    endtask

    task automatic driveInputs();
        logic [DW:0] f;
        for (int i = 0; i < NREQ; i++) begin
            if (beatQ[i].size() > 0) begin
                f = beatQ[i][0];
                req[i] = gate[i];
                last[i] = f[DW];
                din[i*DW +: DW] = f[DW-1:0];
            end else begin
                req[i] = 1'b0;
                last[i] = 1'b0;
                din[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        driveInputs();
    endtask

    task automatic waitDone(input int limit, input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            applyStimulus();
            n++;
            done = !busy;
            for (int i = 0; i < NREQ; i++)
                if (gate[i] && beatQ[i].size() > 0) done = 1'b0;
        end
        checkOutput({name, "_completed_in_budget"}, int'(done), 1);
        applyStimulus();
        applyStimulus();
    endtask

    // Monitor: pops the expected beat of whichever requester the DUT acknowledges.
    logic            busyPrev = 1'b0;
    logic [NREQ-1:0] reqPrev = '0;
    bit              lastWritePrev = 1'b0;
    int              waitCnt [NREQ];

    always @(negedge clk) begin
        logic [DW:0] exp;
        int idx;
        if (lastWritePrev)
            checkOutput("dead_cycle_after_last", int'(busy), 0);
        if (wreset) begin
            checkOutput("reset_winc", int'(winc), 0);
            checkOutput("reset_ack", int'(ack), 0);
            for (int i = 0; i < NREQ; i++) waitCnt[i] = 0;
        end else begin
            if (winc) begin
                writeCnt++;
                idx = int'(owner);
                checkOutput("winc_while_full", int'(full), 0);
                checkOutput("winc_in_idle", int'(busy), 1);
                checkOutput("ack_onehot_owner", int'(ack), 1 << idx);
                checkOutput("write_has_pending_beat", (beatQ[idx].size() > 0) ? 1 : 0, 1);
                if (beatQ[idx].size() > 0) begin
                    exp = beatQ[idx].pop_front();
                    checkOutput("wdata_order", int'(wdata), int'(exp[DW-1:0]));
                end
            end else begin
                checkOutput("ack_without_winc", int'(ack), 0);
            end
            if (err) begin
                errPulses++;
                errWriteMark = writeCnt;
                checkOutput("err_outside_idle", int'(busy), 0);
            end
            if (busy && !busyPrev) begin
                if (checkGrants) begin
                    checkOutput("grant_expected", (grantQ.size() > 0) ? 1 : 0, 1);
                    if (grantQ.size() > 0)
                        checkOutput("grant_owner", int'(owner), grantQ.pop_front());
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (i == int'(owner)) begin
                        waitCnt[i] = 0;
                    end else if (reqPrev[i]) begin
                        waitCnt[i]++;
                        checkOutput("starvation_bound", (waitCnt[i] > NREQ - 1) ? 1 : 0, 0);
                    end else begin
                        waitCnt[i] = 0;
                    end
                end
            end
        end
        lastWritePrev = winc && last[owner] && !wreset;
        busyPrev = busy;
        reqPrev = req;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0, e0, n;

        repeat (3) applyStimulus();
        @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_owner", int'(owner), 0);
        checkOutput("reset_err", int'(err), 0);
        applyStimulus();
        wreset = 1'b0;

        $display("[TB] alternating 3-beat packets from requesters 0 and 2");
        w0 = writeCnt;
        pushPacket(0, 3, 1); pushPacket(0, 3, 1);
        pushPacket(2, 3, 1); pushPacket(2, 3, 1);
        grantQ.push_back(0); grantQ.push_back(2); grantQ.push_back(0); grantQ.push_back(2);
        driveInputs();
        waitDone(200, "alternate");
        checkOutput("alternate_writes", writeCnt - w0, 12);
        checkOutput("alternate_grants_left", grantQ.size(), 0);

        $display("[TB] full back-pressure in the middle of a packet from requester 1");
        grantQ.push_back(1);
        pushPacket(1, 6, 1);
        driveInputs();
        n = 0;
        while (beatQ[1].size() > 4 && n < 50) begin applyStimulus(); n++; end
        e0 = errPulses;
        w0 = writeCnt;
        full = 1'b1;
        repeat (5) applyStimulus();
        checkOutput("writes_during_full", writeCnt - w0, 0);
        full = 1'b0;
        waitDone(100, "full_stall");
        checkOutput("full_stall_no_err", errPulses - e0, 0);
        checkOutput("full_stall_drained", beatQ[1].size(), 0);

        $display("[TB] owner 3 goes silent until the timeout releases it");
        grantQ.push_back(3); grantQ.push_back(1); grantQ.push_back(2);
        pushPacket(3, 4, 1);
        driveInputs();
        n = 0;
        while (beatQ[3].size() > 2 && n < 50) begin applyStimulus(); n++; end
        e0 = errPulses;
        gate[3] = 1'b0;
        pushPacket(1, 2, 1);
        pushPacket(2, 2, 1);
        driveInputs();
        waitDone(200, "timeout");
        checkOutput("timeout_err_pulses", errPulses - e0, 1);
        checkOutput("timeout_grants_left", grantQ.size(), 0);
        beatQ[3].delete();
        gate[3] = 1'b1;
        driveInputs();

        $display("[TB] requester 2 sends MAX_PKT beats with no last");
        grantQ.push_back(2);
        w0 = writeCnt;
        e0 = errPulses;
        pushPacket(2, MAX_PKT, 0);
        driveInputs();
        waitDone(200, "oversize");
        checkOutput("oversize_writes", writeCnt - w0, MAX_PKT);
        checkOutput("oversize_err_pulses", errPulses - e0, 1);
        checkOutput("oversize_err_after_last_beat", errWriteMark - w0, MAX_PKT);

        $display("[TB] reset during beat 2 of a 4-beat packet");
        grantQ.push_back(2);
        pushPacket(2, 4, 1);
        driveInputs();
        n = 0;
        while (beatQ[2].size() > 3 && n < 50) begin applyStimulus(); n++; end
        wreset = 1'b1;
        applyStimulus();
        wreset = 1'b0;
        beatQ[2].delete();
        driveInputs();
        @(negedge clk);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_owner", int'(owner), 0);
        checkOutput("midreset_winc", int'(winc), 0);
        checkOutput("midreset_grants_left", grantQ.size(), 0);
        pushPacket(3, 2, 1);
        pushPacket(1, 2, 1);
        grantQ.push_back(1); grantQ.push_back(3);
        applyStimulus();
        waitDone(100, "after_reset");
        checkOutput("after_reset_grants_left", grantQ.size(), 0);

        $display("[TB] random req/last/full traffic");
        checkGrants = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (beatQ[i].size() == 0 && $urandom_range(0, 3) == 0)
                    pushPacket(i, $urandom_range(1, 6), 1);
            full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                n = $urandom_range(0, NREQ - 1);
                gate[n] = ~gate[n];
            end
            applyStimulus();
        end
        full = 1'b0;
        gate = '1;
        driveInputs();
        waitDone(500, "random");
        for (int i = 0; i < NREQ; i++)
            checkOutput("random_drained", beatQ[i].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
